shift_reg_seq: RTL and testbench

Sequencer for the 8-bit universal shift register. It accepts a parallel word plus a direction and length over a valid/ready handshake. It then drives the register's 2-bit op code and parallel-load bus to load the word, shift it out bit by bit with a per-bit sample strobe, and hold for a configurable inter-frame gap. It sits between a word-level producer and the shift-register datapath, which is clocked by the same `clk`.

---
 rtl/shift_reg_seq_if.sv | 30 +++
 rtl/shift_reg_seq.sv | 153 +++++++++++++++
 tb/tb_shift_reg_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_seq_if.sv
// Producer/datapath bundle for the shift-register sequencer: the frame handshake
// on the producer side and the op/parallel-load/strobe outputs toward the datapath.
interface shift_reg_seq_if #(
  parameter int WIDTH = 8
);
  localparam int LW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [LW-1:0]    in_len;
  logic             abort;
  logic [1:0]       Op;
  logic [WIDTH-1:0] Pin;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [7:0]       frame_cnt;

  modport master (
    output in_valid, in_data, in_dir, in_len, abort,
    input  in_ready, Op, Pin, bit_valid, busy, done, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_len, abort,
    output in_ready, Op, Pin, bit_valid, busy, done, frame_cnt
  );
endinterface

// File: rtl/shift_reg_seq.sv
// Frame sequencer for an 8-bit universal shift register: load a word, shift it out
// with a per-bit sample strobe, then hold for GAP cycles before accepting the next.
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic           clk,
  input  logic           reset,
  shift_reg_seq_if.slave bus
);
  localparam int LW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [LW-1:0] LEN_MAX   = LW'(WIDTH);
  localparam logic [3:0]    GAP_CYCLES = 4'(GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // With no gap configured the frame tail goes straight back to IDLE.
  localparam state_t S_TAIL = (GAP == 0) ? S_IDLE : S_GAP;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_pin;
  logic             r_bit_valid;
  logic             r_done;
  logic [7:0]       r_frame_cnt;
  logic             r_dir;
  logic [LW-1:0]    r_bit_cnt;
  logic [3:0]       r_gap_cnt;

  state_t           w_state_next;
  logic [1:0]       w_op_next;
  logic [WIDTH-1:0] w_pin_next;
  logic             w_bit_valid_next;
  logic             w_done_next;
  logic [7:0]       w_frame_cnt_next;
  logic             w_dir_next;
  logic [LW-1:0]    w_bit_cnt_next;
  logic [3:0]       w_gap_cnt_next;
  logic [LW-1:0]    w_len_clamped;
  logic             w_accept;

  assign w_accept      = bus.in_valid && (r_state == S_IDLE);
  assign w_len_clamped = ((bus.in_len == '0) || (bus.in_len > LEN_MAX)) ? LEN_MAX : bus.in_len;

  always_comb begin
    w_state_next     = r_state;
    w_pin_next       = r_pin;
    w_dir_next       = r_dir;
    w_bit_cnt_next   = r_bit_cnt;
    w_gap_cnt_next   = r_gap_cnt;
    w_done_next      = 1'b0;
    w_frame_cnt_next = r_frame_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next   = S_LOAD;
          w_pin_next     = bus.in_data;
          w_dir_next     = bus.in_dir;
          w_bit_cnt_next = w_len_clamped;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          w_state_next   = S_TAIL;
          w_gap_cnt_next = GAP_CYCLES;
        end else begin
          w_state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_bit_cnt_next = r_bit_cnt - LW'(1);
        // Abort beats completion even on the final bit.
        if (bus.abort) begin
          w_state_next   = S_TAIL;
          w_gap_cnt_next = GAP_CYCLES;
        end else if (r_bit_cnt == LW'(1)) begin
          w_state_next     = S_TAIL;
          w_gap_cnt_next   = GAP_CYCLES;
          w_done_next      = 1'b1;
          w_frame_cnt_next = r_frame_cnt + 8'd1;
        end
      end
      S_GAP: begin
        w_gap_cnt_next = r_gap_cnt - 4'd1;
        if (r_gap_cnt <= 4'd1) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Op and the strobe are decoded from the next state so they are registered
  // outputs that line up with the state they describe.
  always_comb begin
    w_op_next        = OP_HOLD;
    w_bit_valid_next = 1'b0;
    case (w_state_next)
      S_LOAD:  w_op_next = OP_LOAD;
      S_SHIFT: begin
        w_op_next        = w_dir_next ? OP_UP : OP_DOWN;
        w_bit_valid_next = 1'b1;
      end
      default: w_op_next = OP_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_HOLD;
      r_pin       <= '0;
      r_bit_valid <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_dir       <= 1'b0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_op        <= w_op_next;
      r_pin       <= w_pin_next;
      r_bit_valid <= w_bit_valid_next;
      r_done      <= w_done_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_dir       <= w_dir_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.Op        = r_op;
  assign bus.Pin       = r_pin;
  assign bus.bit_valid = r_bit_valid;
  assign bus.done      = r_done;
  assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq: one instance with GAP=2 and one with GAP=0,
// sharing clock and reset, exercised by a linear sequence of steps.
module tb_shift_reg_seq;
  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_fail;

  shift_reg_seq_if #(.WIDTH(8)) bus2 ();
  shift_reg_seq_if #(.WIDTH(8)) bus0 ();

  shift_reg_seq #(.WIDTH(8), .GAP(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  shift_reg_seq #(.WIDTH(8), .GAP(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on the GAP=2 instance; abort_at>0 raises abort in that SHIFT cycle.
  task automatic frame2(input logic [7:0] d, input logic dir, input logic [3:0] len,
                        input int exp_n, input int abort_at, input logic [7:0] exp_cnt);
    int nbits;
    int exp_bits;
    logic [1:0] sop;
    sop = dir ? 2'b01 : 2'b10;
    exp_bits = (abort_at != 0) ? abort_at : exp_n;
    chk("ready_idle", bus2.in_ready, 1);
    bus2.in_valid = 1'b1;
    bus2.in_data  = d;
    bus2.in_dir   = dir;
    bus2.in_len   = len;
    tick();
    bus2.in_valid = 1'b0;
    chk("op_load", bus2.Op, 2'b11);
    chk("pin_load", bus2.Pin, d);
    chk("busy_load", bus2.busy, 1);
    chk("bv_load", bus2.bit_valid, 0);
    tick();
    nbits = 0;
    while (bus2.bit_valid && nbits < 20) begin
      chk("op_shift", bus2.Op, sop);
      nbits++;
      if (nbits == abort_at) bus2.abort = 1'b1;
      tick();
      bus2.abort = 1'b0;
    end
    chk("nbits", nbits, exp_bits);
    chk("op_gap1", bus2.Op, 2'b00);
    chk("done_pulse", bus2.done, (abort_at != 0) ? 0 : 1);
    chk("frame_cnt", bus2.frame_cnt, exp_cnt);
    chk("ready_gap1", bus2.in_ready, 0);
    tick();
    chk("op_gap2", bus2.Op, 2'b00);
    chk("done_clear", bus2.done, 0);
    chk("ready_gap2", bus2.in_ready, 0);
    tick();
    chk("ready_back", bus2.in_ready, 1);
    chk("busy_idle", bus2.busy, 0);
  endtask

  initial begin
    int acc_cnt;
    int done_cnt;
    int w;
    int acc_idx [3];
    logic [7:0] kb;

    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = 8'h00; bus2.in_dir = 1'b0; bus2.in_len = 4'd0; bus2.abort = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = 8'h00; bus0.in_dir = 1'b0; bus0.in_len = 4'd0; bus0.abort = 1'b0;

    #1;
    chk("rst_op", bus2.Op, 2'b00);
    chk("rst_pin", bus2.Pin, 8'h00);
    chk("rst_bv", bus2.bit_valid, 0);
    chk("rst_done", bus2.done, 0);
    chk("rst_cnt", bus2.frame_cnt, 8'h00);
    chk("rst_busy", bus2.busy, 0);
    chk("rst_ready", bus2.in_ready, 1);
    #11 reset = 1'b0;
    tick();

    // Basic frame, short frame, clamping, abort on the 4th bit.
    frame2(8'hA5, 1'b0, 4'd8,  8, 0, 8'd1);
    frame2(8'h5A, 1'b1, 4'd3,  3, 0, 8'd2);
    frame2(8'h3C, 1'b0, 4'd0,  8, 0, 8'd3);
    frame2(8'hC3, 1'b1, 4'd15, 8, 0, 8'd4);
    frame2(8'hF0, 1'b0, 4'd8,  8, 4, 8'd4);
    chk("pin_hold", bus2.Pin, 8'hF0);

    // Abort while idle must not disturb anything.
    bus2.abort = 1'b1;
    tick();
    bus2.abort = 1'b0;
    chk("abort_idle_ready", bus2.in_ready, 1);
    chk("abort_idle_cnt", bus2.frame_cnt, 8'd4);

    // Back-to-back on GAP=0 with in_valid held high.
    acc_cnt  = 0;
    done_cnt = 0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = 8'h81;
    bus0.in_dir   = 1'b1;
    bus0.in_len   = 4'd8;
    for (int i = 0; i <= 30; i++) begin
      if (i == 30) bus0.in_valid = 1'b0;
      if (bus0.in_ready && bus0.in_valid) begin
        if (acc_cnt < 3) acc_idx[acc_cnt] = i;
        acc_cnt++;
      end
      if (bus0.done) done_cnt++;
      if (i == 10) begin
        chk("b2b_done_rdy_done", bus0.done, 1);
        chk("b2b_done_rdy_rdy", bus0.in_ready, 1);
      end
      if (i == 21) chk("b2b_op_load3", bus0.Op, 2'b11);
      if (i == 22) chk("b2b_op_shift3", bus0.Op, 2'b01);
      tick();
    end
    chk("b2b_accepts", acc_cnt, 3);
    chk("b2b_acc1", acc_idx[1], 10);
    chk("b2b_acc2", acc_idx[2], 20);
    chk("b2b_dones", done_cnt, 3);
    chk("b2b_cnt", bus0.frame_cnt, 8'd3);

    // Asynchronous reset in the middle of SHIFT.
    bus2.in_valid = 1'b1;
    bus2.in_data  = 8'h99;
    bus2.in_dir   = 1'b0;
    bus2.in_len   = 4'd8;
    tick();
    bus2.in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_bv", bus2.bit_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_op", bus2.Op, 2'b00);
    chk("arst_busy", bus2.busy, 0);
    chk("arst_bv", bus2.bit_valid, 0);
    chk("arst_cnt", bus2.frame_cnt, 8'd0);
    chk("arst_pin", bus2.Pin, 8'h00);
    #2 reset = 1'b0;
    tick();
    chk("arst_ready", bus2.in_ready, 1);
    chk("arst_done", bus2.done, 0);

    // 256 one-bit frames on GAP=0 wrap frame_cnt back to zero.
    bus0.in_dir = 1'b0;
    bus0.in_len = 4'd1;
    for (int k = 0; k < 256; k++) begin
      w = 0;
      while (!bus0.in_ready && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) chk("wrap_wait", bus0.in_ready, 1);
      if (k == 255) chk("wrap_pre", bus0.frame_cnt, 8'd255);
      kb = 8'(k);
      bus0.in_data  = kb;
      bus0.in_valid = 1'b1;
      tick();
      bus0.in_valid = 1'b0;
    end
    w = 0;
    while (!bus0.in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("wrap_ready", bus0.in_ready, 1);
    chk("wrap_done", bus0.done, 1);
    chk("wrap_cnt", bus0.frame_cnt, 8'd0);
    chk("wrap_pin", bus0.Pin, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
